ir_frame_ctrl: RTL and testbench

IR_FRAME_CTRL -- requirements
Module: ir_frame_ctrl

---
 rtl/ir_frame_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_ir_frame_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_frame_ctrl.sv
// ----------------------------------------------------------------------------
// ir_frame_ctrl
//
// Frame decoder for a pulse-width coded IR receiver. The raw receiver level is
// synchronized, each high pulse is measured and classified as GLITCH, ZERO,
// ONE or START, and a small FSM assembles an LSB-first byte after a start
// marker. Long low gaps inside a frame abort it. A START inside a partially
// received frame aborts that frame and restarts reception.
//
// Optional feature (macro IR_CHECK_EN): when defined, each byte is followed by
// 8 check bits that must equal the bitwise inverse of the byte. A mismatch
// aborts the frame.
//
// Parameters:
//   CNT_W     width of the pulse and gap counters
//   BIT0_MIN  minimum high width (clocks) for a data 0
//   BIT1_MIN  minimum high width for a data 1
//   START_MIN minimum high width for a start marker
//   GAP_MAX   longest low gap tolerated inside a frame
//
// Ports:
//   IR_READER_CLK    sole clock, rising edge
//   IR_READER_RES_N  asynchronous active-low reset
//   ir               raw receiver level (asynchronous), high = pulse active
//   en               high while a frame is in progress
//   rdy              one-cycle strobe, a new byte is on data
//   err              one-cycle strobe, a frame was aborted
//   data             last good byte, updated only with rdy
// ----------------------------------------------------------------------------
module ir_frame_ctrl #(
  parameter int CNT_W     = 8,
  parameter int BIT0_MIN  = 4,
  parameter int BIT1_MIN  = 9,
  parameter int START_MIN = 20,
  parameter int GAP_MAX   = 40
) (
  input  logic       IR_READER_CLK,
  input  logic       IR_READER_RES_N,
  input  logic       ir,
  output logic       en,
  output logic       rdy,
  output logic       err,
  output logic [7:0] data
);

  localparam logic [CNT_W-1:0] LP_BIT0  = CNT_W'(BIT0_MIN);
  localparam logic [CNT_W-1:0] LP_BIT1  = CNT_W'(BIT1_MIN);
  localparam logic [CNT_W-1:0] LP_START = CNT_W'(START_MIN);
  localparam logic [CNT_W-1:0] LP_GAP   = CNT_W'(GAP_MAX);
  localparam logic [CNT_W-1:0] LP_ONE   = CNT_W'(1);

`ifdef IR_CHECK_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_START_SEEN,
    S_BITS,
    S_CHECK
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_START_SEEN,
    S_BITS
  } state_t;
`endif

  typedef enum logic [1:0] {
    C_GLITCH,
    C_ZERO,
    C_ONE,
    C_START
  } cls_t;

  // --------------------------------------------------------------------------
  // Synchronizer and edge detection
  // --------------------------------------------------------------------------
  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic w_rise;
  logic w_fall;

  always_ff @(posedge IR_READER_CLK or negedge IR_READER_RES_N) begin
    if (!IR_READER_RES_N) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= ir;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // r_prev resets low, so the first falling edge after reset can only follow
  // a rising edge seen on the synchronized signal.
  assign w_rise = r_sync2 & ~r_prev;
  assign w_fall = ~r_sync2 & r_prev;

  // --------------------------------------------------------------------------
  // Pulse width counter
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_pcnt;

  // The rising-edge cycle restarts the count and is itself the first high
  // cycle, so at the falling edge r_pcnt equals the number of high cycles.
  always_ff @(posedge IR_READER_CLK or negedge IR_READER_RES_N) begin
    if (!IR_READER_RES_N) begin
      r_pcnt <= '0;
    end else if (w_rise) begin
      r_pcnt <= LP_ONE;
    end else if (r_sync2 && (r_pcnt != '1)) begin
      r_pcnt <= r_pcnt + LP_ONE;
    end
  end

  cls_t w_cls;

  always_comb begin
    w_cls = C_GLITCH;
    if (r_pcnt >= LP_START) begin
      w_cls = C_START;
    end else if (r_pcnt >= LP_BIT1) begin
      w_cls = C_ONE;
    end else if (r_pcnt >= LP_BIT0) begin
      w_cls = C_ZERO;
    end
  end

  logic w_is_bit;
  logic w_is_start;
  logic w_bit;

  assign w_is_bit   = w_fall & ((w_cls == C_ZERO) | (w_cls == C_ONE));
  assign w_is_start = w_fall & (w_cls == C_START);
  assign w_bit      = (w_cls == C_ONE);

  // --------------------------------------------------------------------------
  // Gap counter
  // --------------------------------------------------------------------------
  state_t           r_state;
  logic [CNT_W-1:0] r_gap;
  logic             w_en;
  logic             w_gap_hit;
  logic             w_timeout;

  assign w_en      = (r_state != S_IDLE);
  assign w_gap_hit = w_en & ~r_sync2 & (r_gap >= LP_GAP);
  // A classification in the same cycle takes priority over the timeout.
  assign w_timeout = w_gap_hit & ~w_fall;

  always_ff @(posedge IR_READER_CLK or negedge IR_READER_RES_N) begin
    if (!IR_READER_RES_N) begin
      r_gap <= '0;
    end else if (!w_en || w_rise) begin
      r_gap <= '0;
    end else if (!r_sync2) begin
      if (w_fall && w_gap_hit) begin
        r_gap <= '0;
      end else if (r_gap != '1) begin
        r_gap <= r_gap + LP_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  state_t     w_state_nxt;
  logic [7:0] r_shift;
  logic [7:0] w_shift_nxt;
  logic [2:0] r_idx;
  logic [2:0] w_idx_nxt;
  logic [7:0] r_data;
  logic [7:0] w_data_nxt;
  logic       r_rdy;
  logic       w_rdy_nxt;
  logic       r_err;
  logic       w_err_nxt;
  logic [7:0] w_shifted;
`ifdef IR_CHECK_EN
  logic [7:0] r_byte;
  logic [7:0] w_byte_nxt;
`endif

  assign w_shifted = {w_bit, r_shift[7:1]};

  always_ff @(posedge IR_READER_CLK or negedge IR_READER_RES_N) begin
    if (!IR_READER_RES_N) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_rdy   <= 1'b0;
      r_err   <= 1'b0;
`ifdef IR_CHECK_EN
      r_byte  <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_idx   <= w_idx_nxt;
      r_data  <= w_data_nxt;
      r_rdy   <= w_rdy_nxt;
      r_err   <= w_err_nxt;
`ifdef IR_CHECK_EN
      r_byte  <= w_byte_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_idx;
    w_data_nxt  = r_data;
    w_rdy_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
`ifdef IR_CHECK_EN
    w_byte_nxt  = r_byte;
`endif

    case (r_state)
      S_IDLE: begin
        if (w_is_start) begin
          w_state_nxt = S_START_SEEN;
          w_shift_nxt = '0;
          w_idx_nxt   = '0;
        end
      end

      S_START_SEEN: begin
        if (w_is_start) begin
          w_shift_nxt = '0;
          w_idx_nxt   = '0;
        end else if (w_is_bit) begin
          w_state_nxt = S_BITS;
          w_shift_nxt = w_shifted;
          w_idx_nxt   = 3'd1;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b1;
          w_shift_nxt = '0;
          w_idx_nxt   = '0;
        end
      end

      S_BITS: begin
        if (w_is_start) begin
          w_state_nxt = S_START_SEEN;
          w_err_nxt   = 1'b1;
          w_shift_nxt = '0;
          w_idx_nxt   = '0;
        end else if (w_is_bit) begin
          w_idx_nxt   = r_idx + 3'd1;
          w_shift_nxt = w_shifted;
          if (r_idx == 3'd7) begin
            w_shift_nxt = '0;
`ifdef IR_CHECK_EN
            // The shift register is reused for the check bits; the byte is
            // parked until the check completes.
            w_byte_nxt  = w_shifted;
            w_state_nxt = S_CHECK;
`else
            w_data_nxt  = w_shifted;
            w_rdy_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
`endif
          end
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b1;
          w_shift_nxt = '0;
          w_idx_nxt   = '0;
        end
      end

`ifdef IR_CHECK_EN
      S_CHECK: begin
        if (w_is_start) begin
          w_state_nxt = S_START_SEEN;
          w_err_nxt   = 1'b1;
          w_shift_nxt = '0;
          w_idx_nxt   = '0;
        end else if (w_is_bit) begin
          w_idx_nxt   = r_idx + 3'd1;
          w_shift_nxt = w_shifted;
          if (r_idx == 3'd7) begin
            w_shift_nxt = '0;
            w_state_nxt = S_IDLE;
            if (w_shifted == ~r_byte) begin
              w_data_nxt = r_byte;
              w_rdy_nxt  = 1'b1;
            end else begin
              w_err_nxt  = 1'b1;
            end
          end
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b1;
          w_shift_nxt = '0;
          w_idx_nxt   = '0;
        end
      end
`endif

      default: begin
        w_state_nxt = S_IDLE;
        w_shift_nxt = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign en   = w_en;
  assign rdy  = r_rdy;
  assign err  = r_err;
  assign data = r_data;

endmodule

// File: tb/tb_ir_frame_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ir_frame_ctrl
//
// Scoreboard bench: stimulus is a list of (high width, low gap) pulses. A
// pulse-level reference model decides, for each pulse, whether a byte or an
// abort should be reported and pushes that expectation into a queue. A
// separate monitor pops and compares whenever rdy or err strobes.
// ----------------------------------------------------------------------------
module tb_ir_frame_ctrl;

  localparam int BIT0_MIN  = 4;
  localparam int BIT1_MIN  = 9;
  localparam int START_MIN = 20;
  localparam int GAP_MAX   = 40;
`ifdef IR_CHECK_EN
  localparam int FRAME_BITS = 16;
`else
  localparam int FRAME_BITS = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ir;
  logic       en;
  logic       rdy;
  logic       err;
  logic [7:0] data;

  always #5 clk = ~clk;

  ir_frame_ctrl #(
    .CNT_W    (8),
    .BIT0_MIN (BIT0_MIN),
    .BIT1_MIN (BIT1_MIN),
    .START_MIN(START_MIN),
    .GAP_MAX  (GAP_MAX)
  ) dut (
    .IR_READER_CLK  (clk),
    .IR_READER_RES_N(rst_n),
    .ir             (ir),
    .en             (en),
    .rdy            (rdy),
    .err            (err),
    .data           (data)
  );

  typedef struct packed {
    logic       is_err;
    logic [7:0] d;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec  = 0;
  int  n_miss = 0;

  // Reference model state: pulse-level view of a frame.
  bit          m_active = 1'b0;
  int          m_nbits  = 0;
  int unsigned m_word   = 0;
  logic [7:0]  m_data   = 8'h00;

  task automatic push_ev(input logic is_err, input logic [7:0] d);
    ev_t e;
    e.is_err = is_err;
    e.d      = d;
    exp_q.push_back(e);
  endtask

  task automatic model_edge(input int w);
    int unsigned b;
    int unsigned c;
    if (w < BIT0_MIN) return;
    if (w >= START_MIN) begin
      if (m_active && m_nbits > 0) push_ev(1'b1, m_data);
      m_active = 1'b1;
      m_nbits  = 0;
      m_word   = 0;
      return;
    end
    if (!m_active) return;
    if (w >= BIT1_MIN) m_word = m_word + (32'd1 << m_nbits);
    m_nbits++;
    if (m_nbits == FRAME_BITS) begin
      m_active = 1'b0;
      b = m_word % 256;
      c = (m_word / 256) % 256;
      if (FRAME_BITS == 8 || c == (b ^ 32'hFF)) begin
        m_data = 8'(b);
        push_ev(1'b0, m_data);
      end else begin
        push_ev(1'b1, m_data);
      end
    end
  endtask

  task automatic model_gap(input int l);
    if (m_active && l > GAP_MAX) begin
      push_ev(1'b1, m_data);
      m_active = 1'b0;
    end
  endtask

  task automatic pulse(input int w, input int l);
    ir = 1'b1;
    repeat (w) @(posedge clk);
    #1;
    model_edge(w);
    ir = 1'b0;
    model_gap(l);
    repeat (l) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input bit glitch);
    for (int i = 0; i < 8; i++) begin
      pulse(b[i] ? 10 : 5, 6);
      if (glitch) pulse(2, 3);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit glitch);
    if (glitch) pulse(2, 3);
    pulse(25, 6);
    if (glitch) pulse(2, 3);
    send_bits(b, glitch);
`ifdef IR_CHECK_EN
    send_bits(~b, glitch);
`endif
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expected strobes never seen, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: compares every strobe against the scoreboard.
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    ev_t e;
    if (!rst_n) begin
      prev_data = 8'h00;
    end else begin
      if (rdy && err) begin
        n_vec++;
        n_miss++;
        $display("FAIL strobe_both: rdy=%0b err=%0b, expected not both", rdy, err);
      end else if (rdy || err) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_strobe: rdy=%0b err=%0b data=%0h, expected none", rdy, err, data);
        end else begin
          e = exp_q.pop_front();
          if (e.is_err !== err || e.d !== data) begin
            n_miss++;
            $display("FAIL strobe: err=%0b data=%0h, expected err=%0b data=%0h",
                     err, data, e.is_err, e.d);
          end
        end
      end
      if (data !== prev_data) begin
        n_vec++;
        if (!rdy) begin
          n_miss++;
          $display("FAIL data_change: data %0h->%0h with rdy=%0b, expected rdy=1",
                   prev_data, data, rdy);
        end
      end
      prev_data = data;
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_en"},   32'(en),   32'd0);
    check({tag, "_rdy"},  32'(rdy),  32'd0);
    check({tag, "_err"},  32'(err),  32'd0);
    check({tag, "_data"}, 32'(data), 32'd0);
  endtask

  task automatic rand_width(input int cls, output int w);
    case (cls)
      0: w = int'($urandom_range(1, BIT0_MIN - 1));
      1: w = int'($urandom_range(BIT0_MIN, BIT1_MIN - 1));
      2: w = int'($urandom_range(BIT1_MIN, START_MIN - 1));
      default: w = ($urandom_range(0, 9) == 0) ? 300 : int'($urandom_range(START_MIN, START_MIN + 15));
    endcase
  endtask

  task automatic rand_gap(output int l);
    if ($urandom_range(0, 29) == 0) l = int'($urandom_range(GAP_MAX + 3, GAP_MAX + 20));
    else                            l = int'($urandom_range(3, 30));
  endtask

  initial begin
    int          w;
    int          l;
    logic [15:0] word;
    rst_n = 1'b0;
    ir    = 1'b0;
    #1;
    check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Plain frame A5
    send_frame(8'hA5, 1'b0);
    drain();
    check("frame_a5_data", 32'(data), 32'hA5);
    check("frame_a5_en", 32'(en), 32'd0);

    // Same frame with glitches interleaved
    send_frame(8'hA5, 1'b1);
    drain();
    check("glitch_a5_data", 32'(data), 32'hA5);

    // Gap timeout after three bits
    pulse(25, 6);
    pulse(10, 6);
    pulse(5, 6);
    pulse(10, GAP_MAX + 1);
    drain();
    check("timeout_data", 32'(data), 32'hA5);
    check("timeout_en", 32'(en), 32'd0);

    // Restart: START after four bits, then 3C
    pulse(25, 6);
    for (int i = 0; i < 4; i++) pulse(10, 6);
    send_frame(8'h3C, 1'b0);
    drain();
    check("restart_data", 32'(data), 32'h3C);

`ifdef IR_CHECK_EN
    pulse(25, 6);
    send_bits(8'h5A, 1'b0);
    send_bits(8'hA5, 1'b0);
    drain();
    check("check_ok_data", 32'(data), 32'h5A);
    pulse(25, 6);
    send_bits(8'h5A, 1'b0);
    send_bits(8'hA4, 1'b0);
    drain();
    check("check_bad_data", 32'(data), 32'h5A);
`endif

    // Reset during the fifth bit
    pulse(25, 6);
    for (int i = 0; i < 4; i++) pulse(5, 6);
    ir = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    ir       = 1'b0;
    m_active = 1'b0;
    m_data   = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send_frame(8'hC3, 1'b0);
    drain();
    check("after_reset_data", 32'(data), 32'hC3);

    // Randomized frames with glitches, restarts and long gaps mixed in
    for (int it = 0; it < 40; it++) begin
      word[7:0]  = 8'($urandom_range(0, 255));
      word[15:8] = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : ~word[7:0];
      rand_width(3, w);
      rand_gap(l);
      pulse(w, l);
      for (int i = 0; i < FRAME_BITS; i++) begin
        if ($urandom_range(0, 9) == 0) begin
          rand_width(0, w);
          pulse(w, int'($urandom_range(3, 20)));
        end
        if ($urandom_range(0, 39) == 0) begin
          rand_width(3, w);
          pulse(w, int'($urandom_range(3, 20)));
        end
        rand_width(word[i] ? 2 : 1, w);
        rand_gap(l);
        pulse(w, l);
      end
      drain();
    end
    pulse(25, GAP_MAX + 20);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
